// File: rtl/voq_in_port_ctrl.sv
// Input-port VOQ stage: splits one ingress frame stream into PORT_NUM per-destination queues and forwards whole frames.
// Latency: eop written in cycle N, grant registered at the N+1 edge, first egress word valid in cycle N+2.
// Backpressure: ingress is never back-pressured (frames are admitted or dropped whole); egress stalls on out_ready.
//
// Ports:
//   clk, rst                         clock; asynchronous active-high reset
//   in_valid/in_ready/in_data        ingress word handshake
//   in_sop/in_eop/in_dest            frame delimiters; destination sampled on the sop word
//   dest_full                        per-destination downstream full, gates new grants only
//   out_valid/out_ready/out_data     egress word handshake
//   out_sop/out_eop/out_dest         egress frame delimiters and granted destination
//   drop_cnt, err_cnt                saturating frame-drop and protocol-error counters
module voq_in_port_ctrl #(
  parameter int PORT_NUM   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int MAX_FRAME  = 16,
  parameter int DEST_W     = $clog2(PORT_NUM),
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DEST_W-1:0]     in_dest,
  input  logic [PORT_NUM-1:0]   dest_full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DEST_W-1:0]     out_dest,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_FRAME + 1);
  localparam int EW = DATA_WIDTH + 1;

  localparam logic [DEST_W:0] PORT_LIM = (DEST_W + 1)'(PORT_NUM);
  // free < MAX_FRAME  <=>  occupancy > DEPTH - MAX_FRAME
  localparam logic [OW-1:0]   OCC_LIM  = OW'(DEPTH - MAX_FRAME);
  localparam logic [WW-1:0]   WLAST    = WW'(MAX_FRAME - 1);

  typedef enum logic [1:0] {IN_IDLE, IN_STORE, IN_DROP} in_state_t;
  typedef enum logic       {EG_IDLE, EG_SEND} eg_state_t;

  in_state_t in_st, in_nxt;
  eg_state_t eg_st, eg_nxt;

  // Per-VOQ views exported from the storage generate block.
  logic [OW-1:0]       occ       [PORT_NUM];
  logic [OW-1:0]       frame_cnt [PORT_NUM];
  logic [EW-1:0]       head_arr  [PORT_NUM];
  logic [PORT_NUM-1:0] elig;

  // Ingress datapath / control
  logic              acc;
  logic              dest_bad;
  logic              no_space;
  logic [DEST_W-1:0] dest_q;
  logic [WW-1:0]     wcnt;
  logic              wr_en;
  logic              wr_eop;
  logic [DEST_W-1:0] wr_sel;
  logic              drop_inc;
  logic              err_inc;
  logic              word_limit;

  // Egress control
  logic [DEST_W-1:0] rr_ptr;
  logic [DEST_W-1:0] grant_q;
  logic              first_q;
  logic              found;
  logic [DEST_W-1:0] pick;
  logic [DEST_W:0]   rr_sum;
  logic [DEST_W-1:0] rr_idx;
  logic [EW-1:0]     head;
  logic              pop;
  logic              pop_eop;

  assign acc        = in_valid && in_ready;
  assign dest_bad   = ({1'b0, in_dest} >= PORT_LIM);
  // Registered occupancy only: a same-cycle read is deliberately not credited.
  assign no_space   = occ[dest_bad ? '0 : in_dest] > OCC_LIM;
  assign word_limit = (wcnt == WLAST);

  // Ready is low throughout reset and rises on the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= 1'b1;
  end

  // ---------------------------------------------------------------- ingress FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_st <= IN_IDLE;
    else     in_st <= in_nxt;
  end

  always_comb begin
    in_nxt = in_st;
    case (in_st)
      IN_IDLE: begin
        // A rejected single-word frame has already delivered its eop, so stay idle.
        if (acc && in_sop && !in_eop)
          in_nxt = (dest_bad || no_space) ? IN_DROP : IN_STORE;
      end
      IN_STORE: begin
        if (acc) begin
          if (in_eop)          in_nxt = IN_IDLE;
          else if (word_limit) in_nxt = IN_DROP;
        end
      end
      IN_DROP: begin
        if (acc && in_eop) in_nxt = IN_IDLE;
      end
      default: in_nxt = IN_IDLE;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_eop   = 1'b0;
    wr_sel   = dest_q;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    case (in_st)
      IN_IDLE: begin
        if (acc) begin
          if (!in_sop) begin
            err_inc = 1'b1;
          end else if (dest_bad || no_space) begin
            drop_inc = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_eop = in_eop;
            wr_sel = in_dest;
          end
        end
      end
      IN_STORE: begin
        if (acc) begin
          wr_en   = 1'b1;
          // Oversize frame: close it at the limit so egress still sees a terminated frame.
          wr_eop  = in_eop || word_limit;
          err_inc = !in_eop && word_limit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q   <= '0;
      wcnt     <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (in_st == IN_IDLE && acc && in_sop) dest_q <= in_dest;
      if (wr_en) wcnt <= (in_st == IN_IDLE) ? WW'(1) : wcnt + 1'b1;
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (err_inc  && err_cnt  != '1) err_cnt  <= err_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- VOQ storage
  for (genvar g = 0; g < PORT_NUM; g++) begin : g_voq
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [OW-1:0] oc;
    logic [OW-1:0] fc;
    logic          w;
    logic          r;
    logic          we;
    logic          re;

    assign w  = wr_en && (wr_sel == DEST_W'(g));
    assign r  = pop && (grant_q == DEST_W'(g));
    assign we = w && wr_eop;
    assign re = r && mem[rp][DATA_WIDTH];

    assign head_arr[g]  = mem[rp];
    assign occ[g]       = oc;
    assign frame_cnt[g] = fc;
    assign elig[g]      = (fc != '0) && !dest_full[g];

    always_ff @(posedge clk) begin
      if (w) mem[wp] <= {wr_eop, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp <= '0;
        rp <= '0;
        oc <= '0;
        fc <= '0;
      end else begin
        if (w) wp <= wp + 1'b1;
        if (r) rp <= rp + 1'b1;
        case ({w, r})
          2'b10:   oc <= oc + 1'b1;
          2'b01:   oc <= oc - 1'b1;
          default: ;
        endcase
        case ({we, re})
          2'b10:   fc <= fc + 1'b1;
          2'b01:   fc <= fc - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- egress FSM
  assign head    = head_arr[grant_q];
  assign pop     = (eg_st == EG_SEND) && out_ready;
  assign pop_eop = pop && head[DATA_WIDTH];

  // Round-robin search starting at rr_ptr, wrapping modulo PORT_NUM.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_sum = '0;
    rr_idx = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      rr_sum = {1'b0, rr_ptr} + (DEST_W + 1)'(i);
      if (rr_sum >= PORT_LIM) rr_sum = rr_sum - PORT_LIM;
      rr_idx = rr_sum[DEST_W-1:0];
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) eg_st <= EG_IDLE;
    else     eg_st <= eg_nxt;
  end

  always_comb begin
    eg_nxt = eg_st;
    case (eg_st)
      EG_IDLE: if (found)   eg_nxt = EG_SEND;
      EG_SEND: if (pop_eop) eg_nxt = EG_IDLE;
      default:              eg_nxt = EG_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (eg_st == EG_SEND);
    out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
    out_sop   = out_valid && first_q;
    out_eop   = out_valid && head[DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q  <= '0;
      out_dest <= '0;
      rr_ptr   <= '0;
      first_q  <= 1'b0;
    end else begin
      if (eg_st == EG_IDLE && found) begin
        grant_q  <= pick;
        out_dest <= pick;
        first_q  <= 1'b1;
      end
      if (pop) first_q <= 1'b0;
      if (pop_eop)
        rr_ptr <= (grant_q == DEST_W'(PORT_NUM - 1)) ? '0 : grant_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_voq_in_port_ctrl.sv
module tb_voq_in_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_dest;
  logic [3:0]  dest_full;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_dest;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  voq_in_port_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_dest(in_dest),
    .dest_full(dest_full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_dest(out_dest),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic s, input logic e, input logic [1:0] dst);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_dest  = dst;
    tick();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic push_frame(input logic [1:0] dst, input logic [31:0] base, input int len);
    for (int k = 0; k < len; k++)
      push(base + k, k == 0, k == len - 1, dst);
  endtask

  // Waits (bounded) for a frame, checks every word, then checks the bubble after it.
  task automatic expect_frame(input string tag, input logic [1:0] dst, input logic [31:0] base,
                              input int len, input bit mid, input logic [3:0] mid_full);
    int w;
    w = 0;
    out_ready = 1'b1;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_start"}, out_valid, 1);
    for (int k = 0; k < len; k++) begin
      chk({tag, "_word"}, {out_valid, out_dest, out_sop, out_eop, out_data},
          {1'b1, dst, k == 0, k == len - 1, base + k});
      if (mid && k == 0) dest_full = mid_full;
      tick();
    end
    chk({tag, "_gap"}, out_valid, 0);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk(tag, out_valid, 0);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_dest   = '0;
    dest_full = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outs", {out_valid, out_sop, out_eop, out_dest, out_data}, 0);
    chk("rst_cnts", {drop_cnt, err_cnt}, 0);
    rst = 1'b0;
    chk("rst_ready_hold", in_ready, 0);
    tick();
    chk("ready_after_rst", in_ready, 1);

    // 1: one-word frame, minimum latency
    push(32'hA5A5_A5A5, 1'b1, 1'b1, 2'd2);
    chk("t1_n1", out_valid, 0);
    tick();
    chk("t1_word", {out_valid, out_dest, out_sop, out_eop, out_data}, {1'b1, 2'd2, 1'b1, 1'b1, 32'hA5A5_A5A5});
    tick();
    chk("t1_gap", out_valid, 0);

    // 2: round-robin order over destinations 0, 1, 3
    do_reset();
    dest_full = 4'b1111;
    push_frame(2'd0, 32'h2000_0000, 3);
    push_frame(2'd1, 32'h2100_0000, 3);
    push_frame(2'd3, 32'h2300_0000, 3);
    idle_check("t2_held", 2);
    dest_full = 4'b0000;
    expect_frame("t2_d0", 2'd0, 32'h2000_0000, 3, 1'b0, 4'b0);
    expect_frame("t2_d1", 2'd1, 32'h2100_0000, 3, 1'b0, 4'b0);
    expect_frame("t2_d3", 2'd3, 32'h2300_0000, 3, 1'b0, 4'b0);
    chk("t2_rr", dut.rr_ptr, 0);

    // 3: admission boundary on dest 1 (48 words leaves exactly 16 free, 49 leaves 15)
    dest_full = 4'b0010;
    for (int f = 0; f < 3; f++) push_frame(2'd1, 32'h3000_0000 + f * 32'h100, 16);
    push_frame(2'd1, 32'h3000_0300, 1);
    chk("t3_occ49", dut.occ[1], 49);
    chk("t3_no_drop_yet", drop_cnt, 0);
    push(32'h3000_0400, 1'b1, 1'b0, 2'd1);
    chk("t3_ready", in_ready, 1);
    chk("t3_drop", drop_cnt, 1);
    push(32'h3000_0401, 1'b0, 1'b0, 2'd1);
    push(32'h3000_0402, 1'b0, 1'b0, 2'd1);
    push(32'h3000_0403, 1'b0, 1'b1, 2'd1);
    chk("t3_occ_kept", dut.occ[1], 49);
    chk("t3_err", err_cnt, 0);
    dest_full = 4'b0000;
    for (int f = 0; f < 3; f++) expect_frame("t3_full", 2'd1, 32'h3000_0000 + f * 32'h100, 16, 1'b0, 4'b0);
    expect_frame("t3_one", 2'd1, 32'h3000_0300, 1, 1'b0, 4'b0);
    idle_check("t3_dropped_absent", 3);

    // 4: oversize frame is truncated at 16 words; stray word is an error
    dest_full = 4'b1111;
    push_frame(2'd2, 32'h4000_0000, 20);
    chk("t4_err", err_cnt, 1);
    push(32'h4000_0FFF, 1'b0, 1'b0, 2'd0);
    chk("t4_stray", err_cnt, 2);
    push_frame(2'd3, 32'h4300_0000, 2);
    dest_full = 4'b0000;
    expect_frame("t4_trunc", 2'd2, 32'h4000_0000, 16, 1'b0, 4'b0);
    expect_frame("t4_next", 2'd3, 32'h4300_0000, 2, 1'b0, 4'b0);
    chk("t4_drop_same", drop_cnt, 1);

    // 5: dest_full skips dest 0; raising it mid-frame does not stop the frame
    dest_full = 4'b1111;
    push_frame(2'd0, 32'h5000_0000, 4);
    push_frame(2'd2, 32'h5200_0000, 3);
    dest_full = 4'b0001;
    expect_frame("t5_d2", 2'd2, 32'h5200_0000, 3, 1'b0, 4'b0);
    idle_check("t5_blocked", 3);
    dest_full = 4'b0000;
    expect_frame("t5_d0", 2'd0, 32'h5000_0000, 4, 1'b1, 4'b0001);
    dest_full = 4'b0000;

    // 6: simultaneous eop write and eop read on dest 1
    out_ready = 1'b0;
    push_frame(2'd1, 32'h6000_0000, 2);
    tick();
    chk("t6_a0", {out_valid, out_dest, out_sop, out_data}, {1'b1, 2'd1, 1'b1, 32'h6000_0000});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_a1", {out_valid, out_sop, out_eop, out_data}, {1'b1, 1'b0, 1'b1, 32'h6000_0001});
    push(32'h6100_0000, 1'b1, 1'b0, 2'd1);
    out_ready = 1'b1;
    push(32'h6100_0001, 1'b0, 1'b1, 2'd1);
    out_ready = 1'b0;
    chk("t6_fcnt", dut.frame_cnt[1], 1);
    chk("t6_bubble", out_valid, 0);
    expect_frame("t6_b", 2'd1, 32'h6100_0000, 2, 1'b0, 4'b0);
    chk("t6_empty", {dut.occ[1], dut.frame_cnt[1]}, 0);

    // Reset mid-frame flushes everything
    dest_full = 4'b0100;
    push_frame(2'd2, 32'h7000_0000, 2);
    push(32'h7100_0000, 1'b1, 1'b0, 2'd0);
    push(32'h7100_0001, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    chk("mr_in_ready", in_ready, 0);
    chk("mr_outs", {out_valid, out_sop, out_eop, out_dest, out_data}, 0);
    chk("mr_cnts", {drop_cnt, err_cnt}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_ready", in_ready, 1);
    dest_full = 4'b0000;
    idle_check("mr_flushed", 4);
    chk("mr_occ", {dut.occ[0], dut.occ[2]}, 0);
    push_frame(2'd3, 32'h8000_0000, 1);
    expect_frame("mr_after", 2'd3, 32'h8000_0000, 1, 1'b0, 4'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/voq_in_port_ctrl.md
Name: voq_in_port_ctrl

Overview:
- Parametrised next-generation input-port VOQ stage for the shared-cache switch.
- Splits one ingress frame stream into PORT_NUM per-destination virtual output queues (VOQs) and applies frame-level admission: a frame is either stored whole or dropped whole.
- Forwards only complete frames (store-and-forward), choosing among destinations round-robin and skipping destinations whose downstream VOQ is full.
- Sits between the ingress MAC/parser and the shared-memory write arbiter.

Parameters:
PORT_NUM, 4, number of destinations / VOQs (>=2)
DATA_WIDTH, 32, payload word width
DEPTH, 64, words per VOQ (power of two)
MAX_FRAME, 16, maximum frame length in words (<= DEPTH)
DEST_W, $clog2(PORT_NUM), destination field width
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  ingress word valid
in_ready  out  1  ingress accept
in_data  in  DATA_WIDTH  ingress word
in_sop  in  1  first word of frame
in_eop  in  1  last word of frame
in_dest  in  DEST_W  destination; sampled on the sop word only
dest_full  in  PORT_NUM  per-destination downstream VOQ full
out_valid  out  1  egress word valid
out_ready  in  1  egress accept
out_data  out  DATA_WIDTH  egress word
out_sop  out  1  first word of frame
out_eop  out  1  last word of frame
out_dest  out  DEST_W  destination of the current frame
drop_cnt  out  CNT_W  frames dropped (no space or bad destination)
err_cnt  out  CNT_W  protocol errors (stray word, oversize frame)

Behaviour:
- Reset values: in_ready=0 while rst is high, 1 from the first clock after release. out_valid, out_sop and out_eop are 0. out_data, out_dest, drop_cnt and err_cnt are 0. All VOQ pointers, occupancies and frame counts are 0. Round-robin pointer is 0.
- Reset asserted mid-frame flushes all queues immediately; partial frames are lost.
- in_ready stays 1 outside reset. Admission never back-pressures the source.
- VOQ storage: each entry is {eop, data}. The read head is combinational from the register array.
- Ingress FSM states: IDLE, STORE, DROP.
  - IDLE, valid word with sop:
    - If in_dest >= PORT_NUM, or free(in_dest) < MAX_FRAME: drop_cnt+1, go to DROP.
    - Otherwise write the word and go to STORE.
    - free = DEPTH - occupancy, using the registered occupancy. A read in the same cycle is not credited.
    - sop with eop is a one-word frame: written, frame complete, stay in IDLE.
  - IDLE, valid word without sop: discard, err_cnt+1.
  - STORE: write every valid word to the latched destination.
    - eop: frame complete, go to IDLE.
    - in_sop is ignored in STORE.
    - If word count reaches MAX_FRAME without eop: write that word with the eop bit forced to 1, err_cnt+1, go to DROP.
  - DROP: discard valid words until eop, then go to IDLE.
- Frame count per VOQ:
  - +1 on the cycle an eop-marked word is written; visible on the next cycle.
  - -1 when the egress eop handshake completes.
  - If both happen in the same cycle, the count is unchanged.
- Egress FSM states: IDLE, SEND.
  - IDLE: the eligible set is VOQs with frame_cnt>0 and dest_full[d]=0. Grant the first eligible d searching from rr_ptr upward with wrap-around. Register the grant and out_dest, then go to SEND. No eligible VOQ: stay in IDLE.
  - SEND: out_valid=1 and out_data is the head of the granted VOQ. out_sop=1 on the first word and out_eop equals the stored eop bit. Each out_valid&&out_ready pops one word.
  - dest_full is ignored once in SEND; the frame always completes.
  - SEND, eop handshake: rr_ptr = grant+1 mod PORT_NUM, go to IDLE. This gives one bubble cycle between frames.
- Minimum latency: eop written in cycle N, grant registered at the N+1 edge, out_valid in cycle N+2.
- Occupancy is exact under a simultaneous write and read on the same VOQ. A VOQ never overflows or underflows.
- Both statistics counters saturate at all-ones.

Test Plan:
1. One-word frame to dest 2 (sop=eop=1, data 0xA5A5A5A5) -> out_valid two cycles later; out_dest=2, sop=eop=1, data 0xA5A5A5A5.
2. Complete 3-word frames queued on dest 0, 1 and 3, out_ready=1 -> egress order 0,1,3; rr_ptr ends at 0; one bubble between frames.
3. Fill dest 1 to 49 words (free 15 < MAX_FRAME 16), then send a 4-word frame to dest 1 -> frame dropped, drop_cnt=1, occupancy unchanged, in_ready stays 1.
4. 20-word frame without eop before word 16 -> 16 words stored with the last eop-marked; words 17-20 discarded; err_cnt=1; next sop accepted normally.
5. dest_full[0]=1 with frames on dest 0 and 2 -> dest 2 is sent first; dest_full[0] raised mid-frame on dest 0 does not stop that frame.
6. Simultaneous eop write and eop read on dest 1 -> frame_cnt unchanged. Assert rst mid-frame -> all outputs at reset values, queues empty.
